ddr4_cmd_sched: RTL and testbench

Parametrised successor to the DDR4 controller state machine: a single-rank command scheduler that runs the mode-register init sequence, tracks an open row per bank, turns read/write requests into ACT/RD/WR/PRE commands with enforced timing gaps, and inserts auto-refresh from an internal tREFI timer. It sits between the request front end (switches/host logic) and the DDR4 PHY command driver. `state_out` feeds the board HEX/LED status display.

---
 rtl/ddr4_pkg.sv | 39 +++
 rtl/ddr4_refresh_timer.sv | 41 ++++
 rtl/ddr4_cmd_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_ddr4_cmd_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared encodings and default timing for the DDR4 command scheduler.
package ddr4_pkg;

    // Command bus encoding seen by the PHY command driver.
    typedef enum logic [2:0] {
        CmdNop  = 3'd0,
        CmdMrs  = 3'd1,
        CmdAct  = 3'd2,
        CmdRd   = 3'd3,
        CmdWr   = 3'd4,
        CmdPre  = 3'd5,
        CmdPrea = 3'd6,
        CmdRef  = 3'd7
    } cmd_e;

    // Scheduler state encoding; also drives the status display.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StInit      = 3'd1,
        StReady     = 3'd2,
        StActivate  = 3'd3,
        StRw        = 3'd4,
        StPrecharge = 3'd5,
        StRefresh   = 3'd6
    } state_e;

    localparam int unsigned N_MRS_DEF = 7;
    localparam int unsigned T_MOD_DEF = 24;
    localparam int unsigned T_RCD_DEF = 16;
    localparam int unsigned T_RP_DEF = 16;
    localparam int unsigned T_CCD_DEF = 4;
    localparam int unsigned T_RFC_DEF = 280;
    localparam int unsigned T_REFI_DEF = 7800;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_refresh_timer.sv
// tREFI interval timer with a single sticky refresh-pending flag.
module ddr4_refresh_timer
    import ddr4_pkg::*;
#(
    parameter int unsigned tREFI = T_REFI_DEF
) (
    input  logic CK_t,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pending
);

    localparam int unsigned CNT_W = $clog2(tREFI) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic             pending_q;

    // Free-running interval count; an expiry while already pending is absorbed.
    always_ff @(posedge CK_t) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            if (clr) begin
                pending_q <= 1'b0;
            end
            if (en) begin
                if (cnt_q == CNT_W'(tREFI - 1)) begin
                    cnt_q     <= '0;
                    pending_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/ddr4_cmd_sched.sv
// Single-rank DDR4 command scheduler: MRS init, open-row tracking, ACT/RD/WR/PRE
// generation with timing gaps, and auto-refresh insertion.
module ddr4_cmd_sched
    import ddr4_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned ROW_W     = 16,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned N_MRS     = N_MRS_DEF,
    parameter int unsigned tMOD      = T_MOD_DEF,
    parameter int unsigned tRCD      = T_RCD_DEF,
    parameter int unsigned tRP       = T_RP_DEF,
    parameter int unsigned tCCD      = T_CCD_DEF,
    parameter int unsigned tRFC      = T_RFC_DEF,
    parameter int unsigned tREFI     = T_REFI_DEF,
    localparam int unsigned BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic              CK_t,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic [2:0]        cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              init_done,
    output logic              busy,
    output logic [2:0]        state_out
);

    localparam int unsigned T_MAX =
        max_u(max_u(max_u(tMOD, tRCD), max_u(tRP, tCCD)), max_u(tRFC, tREFI));
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;
    localparam int unsigned MR_W  = $clog2(N_MRS) + 1;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [MR_W-1:0]                 mr_idx_q, mr_idx_d;
    cmd_e                            cmd_q, cmd_d;
    logic [BANK_W-1:0]               cmd_bank_q, cmd_bank_d;
    logic [ROW_W-1:0]                cmd_row_q, cmd_row_d;
    logic [COL_W-1:0]                cmd_col_q, cmd_col_d;
    logic                            init_done_q, init_done_d;
    logic                            hold_we_q, hold_we_d;
    logic [BANK_W-1:0]               hold_bank_q, hold_bank_d;
    logic [ROW_W-1:0]                hold_row_q, hold_row_d;
    logic [COL_W-1:0]                hold_col_q, hold_col_d;
    logic [NUM_BANKS-1:0]            bank_open_q, bank_open_d;
    logic [NUM_BANKS-1:0][ROW_W-1:0] open_row_q, open_row_d;
    logic                            ref_pre_q, ref_pre_d;   // REFRESH is in its PREA gap
    logic                            ref_issue;
    logic                            ref_pending;

    ddr4_refresh_timer #(
        .tREFI (tREFI)
    ) u_refresh_timer (
        .CK_t    (CK_t),
        .rst     (rst),
        .en      (init_done_q),
        .clr     (ref_issue),
        .pending (ref_pending)
    );

    // State and registered command outputs; reset aborts everything without a PRE.
    always_ff @(posedge CK_t) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mr_idx_q    <= '0;
            cmd_q       <= CmdNop;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            init_done_q <= 1'b0;
            hold_we_q   <= 1'b0;
            hold_bank_q <= '0;
            hold_row_q  <= '0;
            hold_col_q  <= '0;
            bank_open_q <= '0;
            open_row_q  <= '0;
            ref_pre_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mr_idx_q    <= mr_idx_d;
            cmd_q       <= cmd_d;
            cmd_bank_q  <= cmd_bank_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            init_done_q <= init_done_d;
            hold_we_q   <= hold_we_d;
            hold_bank_q <= hold_bank_d;
            hold_row_q  <= hold_row_d;
            hold_col_q  <= hold_col_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            ref_pre_q   <= ref_pre_d;
        end
    end

    // Next state: each transition issues the command of the state being entered
    // and loads the wait counter with that command's gap minus one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mr_idx_d    = mr_idx_q;
        cmd_d       = CmdNop;
        cmd_bank_d  = cmd_bank_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        init_done_d = init_done_q;
        hold_we_d   = hold_we_q;
        hold_bank_d = hold_bank_q;
        hold_row_d  = hold_row_q;
        hold_col_d  = hold_col_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        ref_pre_d   = ref_pre_q;
        ref_issue   = 1'b0;

        case (state_q)
            StIdle: begin
                state_d   = StInit;
                cmd_d     = CmdMrs;
                cmd_row_d = '0;
                mr_idx_d  = '0;
                cnt_d     = CNT_W'(tMOD - 1);
            end
            StInit: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (mr_idx_q == MR_W'(N_MRS - 1)) begin
                    state_d     = StReady;
                    init_done_d = 1'b1;
                end else begin
                    mr_idx_d  = mr_idx_q + 1'b1;
                    cmd_d     = CmdMrs;
                    cmd_row_d = ROW_W'(mr_idx_q + 1'b1);
                    cnt_d     = CNT_W'(tMOD - 1);
                end
            end
            StReady: begin
                if (ref_pending) begin
                    state_d = StRefresh;
                    if (|bank_open_q) begin
                        cmd_d       = CmdPrea;
                        bank_open_d = '0;
                        ref_pre_d   = 1'b1;
                        cnt_d       = CNT_W'(tRP - 1);
                    end else begin
                        cmd_d     = CmdRef;
                        ref_issue = 1'b1;
                        ref_pre_d = 1'b0;
                        cnt_d     = CNT_W'(tRFC - 1);
                    end
                end else if (req_valid) begin
                    hold_we_d   = req_we;
                    hold_bank_d = req_bank;
                    hold_row_d  = req_row;
                    hold_col_d  = req_col;
                    cmd_bank_d  = req_bank;
                    if (!bank_open_q[req_bank]) begin
                        state_d               = StActivate;
                        cmd_d                 = CmdAct;
                        cmd_row_d             = req_row;
                        bank_open_d[req_bank] = 1'b1;
                        open_row_d[req_bank]  = req_row;
                        cnt_d                 = CNT_W'(tRCD - 1);
                    end else if (open_row_q[req_bank] == req_row) begin
                        state_d   = StRw;
                        cmd_d     = req_we ? CmdWr : CmdRd;
                        cmd_col_d = req_col;
                        cnt_d     = CNT_W'(tCCD - 1);
                    end else begin
                        state_d               = StPrecharge;
                        cmd_d                 = CmdPre;
                        bank_open_d[req_bank] = 1'b0;
                        cnt_d                 = CNT_W'(tRP - 1);
                    end
                end
            end
            StPrecharge: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d                  = StActivate;
                    cmd_d                    = CmdAct;
                    cmd_bank_d               = hold_bank_q;
                    cmd_row_d                = hold_row_q;
                    bank_open_d[hold_bank_q] = 1'b1;
                    open_row_d[hold_bank_q]  = hold_row_q;
                    cnt_d                    = CNT_W'(tRCD - 1);
                end
            end
            StActivate: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d    = StRw;
                    cmd_d      = hold_we_q ? CmdWr : CmdRd;
                    cmd_bank_d = hold_bank_q;
                    cmd_col_d  = hold_col_q;
                    cnt_d      = CNT_W'(tCCD - 1);
                end
            end
            StRw: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StReady;
                end
            end
            StRefresh: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (ref_pre_q) begin
                    cmd_d     = CmdRef;
                    ref_issue = 1'b1;
                    ref_pre_d = 1'b0;
                    cnt_d     = CNT_W'(tRFC - 1);
                end else begin
                    state_d = StReady;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready = (state_q == StReady) && !ref_pending;
    assign busy      = (state_q != StReady);
    assign state_out = state_q;
    assign cmd       = cmd_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_ddr4_cmd_sched.sv
// Directed bench for ddr4_cmd_sched with small timing parameters.
module tb_ddr4_cmd_sched;

    logic        CK_t;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bank;
    logic [15:0] req_row;
    logic [9:0]  req_col;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        init_done;
    logic        busy;
    logic [2:0]  state_out;

    int vec;
    int miss;
    int cyc;

    typedef struct {
        int          c;
        logic [2:0]  op;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } ent_t;

    ent_t log_q[$];

    ddr4_cmd_sched #(
        .NUM_BANKS (4),
        .ROW_W     (16),
        .COL_W     (10),
        .N_MRS     (3),
        .tMOD      (4),
        .tRCD      (3),
        .tRP       (2),
        .tCCD      (4),
        .tRFC      (10),
        .tREFI     (50)
    ) dut (
        .CK_t      (CK_t),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_col   (req_col),
        .cmd       (cmd),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .init_done (init_done),
        .busy      (busy),
        .state_out (state_out)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    // Cycle 0 is the first cycle with rst low; counts edges after that.
    always @(posedge CK_t) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Record every non-NOP command with its cycle stamp.
    always @(negedge CK_t) begin
        if (!rst && cmd != 3'd0) begin
            log_q.push_back('{c: cyc, op: cmd, bank: cmd_bank, row: cmd_row, col: cmd_col});
        end
    end

    task automatic get_cmd(output ent_t e, output bit ok);
        ok = 1'b0;
        e  = '{c: -1, op: 3'd0, bank: 2'd0, row: 16'd0, col: 10'd0};
        for (int i = 0; i < 400; i++) begin
            if (log_q.size() > 0) begin
                e  = log_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge CK_t);
        end
    endtask

    task automatic wait_until(input int target, output bit ok);
        for (int i = 0; i < 2000 && cyc < target; i++) @(negedge CK_t);
        ok = (cyc == target);
    endtask

    // Holds the request until accepted; n is the accept cycle or -1 on timeout.
    task automatic send_req(input logic we, input logic [1:0] b, input logic [15:0] r,
                            input logic [9:0] c, output int n);
        req_we    = we;
        req_bank  = b;
        req_row   = r;
        req_col   = c;
        req_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 200 && n < 0; i++) begin
            if (req_ready) n = cyc;
            @(negedge CK_t);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CK_t);
        vec++; if (cmd !== 3'd0) begin miss++; $display("FAIL rst_cmd got %0d want 0", cmd); end
        vec++; if (cmd_bank !== 2'd0 || cmd_row !== 16'd0 || cmd_col !== 10'd0) begin
            miss++; $display("FAIL rst_fields got %0d/%h/%h want 0/0/0", cmd_bank, cmd_row, cmd_col);
        end
        vec++; if (req_ready !== 1'b0) begin miss++; $display("FAIL rst_ready got %b want 0", req_ready); end
        vec++; if (init_done !== 1'b0) begin miss++; $display("FAIL rst_init got %b want 0", init_done); end
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL rst_busy got %b want 1", busy); end
        vec++; if (state_out !== 3'd0) begin miss++; $display("FAIL rst_state got %0d want 0", state_out); end
    endtask

    task automatic test_init();
        ent_t e; bit ok;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_cmd(e, ok);
            vec++;
            if (!ok || e.op !== 3'd1 || e.c != 1 + 4 * i || e.row !== 16'(i)) begin
                miss++;
                $display("FAIL init_mrs%0d got op=%0d cyc=%0d row=%0d want op=1 cyc=%0d row=%0d",
                         i, e.op, e.c, e.row, 1 + 4 * i, i);
            end
        end
        wait_until(12, ok);
        vec++; if (!ok || init_done !== 1'b0 || state_out !== 3'd1) begin
            miss++; $display("FAIL init_c12 got done=%b st=%0d want 0/1", init_done, state_out);
        end
        wait_until(13, ok);
        vec++; if (!ok || init_done !== 1'b1 || state_out !== 3'd2 || busy !== 1'b0) begin
            miss++; $display("FAIL init_c13 got done=%b st=%0d busy=%b want 1/2/0",
                             init_done, state_out, busy);
        end
    endtask

    task automatic test_refresh_idle();
        ent_t e; bit ok;
        wait_until(62, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL ri_c62 got %b want 1", req_ready); end
        wait_until(63, ok);
        vec++; if (!ok || req_ready !== 1'b0 || state_out !== 3'd2) begin
            miss++; $display("FAIL ri_c63 got rdy=%b st=%0d want 0/2", req_ready, state_out);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd7 || e.c != 64) begin
            miss++; $display("FAIL ri_ref got op=%0d cyc=%0d want op=7 cyc=64", e.op, e.c);
        end
        wait_until(73, ok);
        vec++; if (!ok || state_out !== 3'd6 || busy !== 1'b1) begin
            miss++; $display("FAIL ri_c73 got st=%0d busy=%b want 6/1", state_out, busy);
        end
        wait_until(74, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL ri_c74 got %b want 1", req_ready); end
    endtask

    task automatic test_read_closed();
        ent_t e; bit ok; int n;
        send_req(1'b0, 2'd2, 16'h0012, 10'h005, n);
        vec++; if (n != 74) begin miss++; $display("FAIL rd_accept got %0d want 74", n); end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd2 || e.c != n + 1 || e.bank !== 2'd2 || e.row !== 16'h0012) begin
            miss++; $display("FAIL rd_act got op=%0d cyc=%0d b=%0d row=%h want 2/%0d/2/0012",
                             e.op, e.c, e.bank, e.row, n + 1);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd3 || e.c != n + 4 || e.bank !== 2'd2 || e.col !== 10'h005) begin
            miss++; $display("FAIL rd_rd got op=%0d cyc=%0d b=%0d col=%h want 3/%0d/2/005",
                             e.op, e.c, e.bank, e.col, n + 4);
        end
        wait_until(n + 7, ok);
        vec++; if (!ok || req_ready !== 1'b0) begin miss++; $display("FAIL rd_rdy_early got %b want 0", req_ready); end
        wait_until(n + 8, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL rd_rdy got %b want 1", req_ready); end
    endtask

    task automatic test_write_hit();
        ent_t e; bit ok; int n;
        send_req(1'b1, 2'd2, 16'h0012, 10'h006, n);
        get_cmd(e, ok);
        vec++; if (n < 0 || !ok || e.op !== 3'd4 || e.c != n + 1 || e.bank !== 2'd2 || e.col !== 10'h006) begin
            miss++; $display("FAIL wh_wr got op=%0d cyc=%0d b=%0d col=%h want 4/%0d/2/006",
                             e.op, e.c, e.bank, e.col, n + 1);
        end
        wait_until(n + 4, ok);
        vec++; if (!ok || req_ready !== 1'b0) begin miss++; $display("FAIL wh_rdy_early got %b want 0", req_ready); end
        wait_until(n + 5, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL wh_rdy got %b want 1", req_ready); end
    endtask

    task automatic test_row_conflict();
        ent_t e; bit ok; int n;
        send_req(1'b1, 2'd2, 16'h0034, 10'h007, n);
        get_cmd(e, ok);
        vec++; if (n < 0 || !ok || e.op !== 3'd5 || e.c != n + 1 || e.bank !== 2'd2) begin
            miss++; $display("FAIL rc_pre got op=%0d cyc=%0d b=%0d want 5/%0d/2", e.op, e.c, e.bank, n + 1);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd2 || e.c != n + 3 || e.bank !== 2'd2 || e.row !== 16'h0034) begin
            miss++; $display("FAIL rc_act got op=%0d cyc=%0d b=%0d row=%h want 2/%0d/2/0034",
                             e.op, e.c, e.bank, e.row, n + 3);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd4 || e.c != n + 6 || e.col !== 10'h007) begin
            miss++; $display("FAIL rc_wr got op=%0d cyc=%0d col=%h want 4/%0d/007", e.op, e.c, e.col, n + 6);
        end
    endtask

    task automatic test_refresh_open();
        ent_t e; bit ok; int n;
        wait_until(112, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL ro_c112 got %b want 1", req_ready); end
        @(negedge CK_t);
        req_we = 1'b0; req_bank = 2'd1; req_row = 16'h0055; req_col = 10'h008; req_valid = 1'b1;
        vec++; if (req_ready !== 1'b0) begin miss++; $display("FAIL ro_c113 got %b want 0", req_ready); end
        send_req(1'b0, 2'd1, 16'h0055, 10'h008, n);
        vec++; if (n != 126) begin miss++; $display("FAIL ro_accept got %0d want 126", n); end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd6 || e.c != 114) begin
            miss++; $display("FAIL ro_prea got op=%0d cyc=%0d want 6/114", e.op, e.c);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd7 || e.c != 116) begin
            miss++; $display("FAIL ro_ref got op=%0d cyc=%0d want 7/116", e.op, e.c);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd2 || e.c != 127 || e.bank !== 2'd1 || e.row !== 16'h0055) begin
            miss++; $display("FAIL ro_act got op=%0d cyc=%0d b=%0d row=%h want 2/127/1/0055",
                             e.op, e.c, e.bank, e.row);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd3 || e.c != 130 || e.col !== 10'h008) begin
            miss++; $display("FAIL ro_rd got op=%0d cyc=%0d col=%h want 3/130/008", e.op, e.c, e.col);
        end
    endtask

    task automatic test_refresh_mid_act();
        ent_t e; bit ok; int n;
        wait_until(161, ok);
        send_req(1'b0, 2'd3, 16'h0077, 10'h003, n);
        vec++; if (!ok || n != 161) begin miss++; $display("FAIL ma_accept got %0d want 161", n); end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd2 || e.c != 162 || e.bank !== 2'd3) begin
            miss++; $display("FAIL ma_act got op=%0d cyc=%0d b=%0d want 2/162/3", e.op, e.c, e.bank);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd3 || e.c != 165 || e.col !== 10'h003) begin
            miss++; $display("FAIL ma_rd got op=%0d cyc=%0d col=%h want 3/165/003", e.op, e.c, e.col);
        end
        wait_until(169, ok);
        vec++; if (!ok || req_ready !== 1'b0 || state_out !== 3'd2) begin
            miss++; $display("FAIL ma_c169 got rdy=%b st=%0d want 0/2", req_ready, state_out);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd6 || e.c != 170) begin
            miss++; $display("FAIL ma_prea got op=%0d cyc=%0d want 6/170", e.op, e.c);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd7 || e.c != 172) begin
            miss++; $display("FAIL ma_ref got op=%0d cyc=%0d want 7/172", e.op, e.c);
        end
        wait_until(182, ok);
        vec++; if (!ok || req_ready !== 1'b1) begin miss++; $display("FAIL ma_c182 got %b want 1", req_ready); end
    endtask

    task automatic test_rst_mid_rw();
        ent_t e; bit ok; int n;
        send_req(1'b1, 2'd1, 16'h0009, 10'h010, n);
        get_cmd(e, ok);
        get_cmd(e, ok);
        vec++; if (n != 182 || !ok || e.op !== 3'd4 || e.c != 186) begin
            miss++; $display("FAIL rr_wr got acc=%0d op=%0d cyc=%0d want 182/4/186", n, e.op, e.c);
        end
        wait_until(187, ok);
        vec++; if (!ok || state_out !== 3'd4 || busy !== 1'b1) begin
            miss++; $display("FAIL rr_c187 got st=%0d busy=%b want 4/1", state_out, busy);
        end
        rst = 1'b1;
        @(negedge CK_t);
        vec++; if (cmd !== 3'd0 || cmd_bank !== 2'd0 || cmd_row !== 16'd0 || cmd_col !== 10'd0) begin
            miss++; $display("FAIL rr_fields got %0d/%0d/%h/%h want 0/0/0/0", cmd, cmd_bank, cmd_row, cmd_col);
        end
        vec++; if (req_ready !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1 || state_out !== 3'd0) begin
            miss++; $display("FAIL rr_status got rdy=%b done=%b busy=%b st=%0d want 0/0/1/0",
                             req_ready, init_done, busy, state_out);
        end
        rst = 1'b0;
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd1 || e.c != 1 || e.row !== 16'd0) begin
            miss++; $display("FAIL rr_mr0 got op=%0d cyc=%0d row=%0d want 1/1/0", e.op, e.c, e.row);
        end
        get_cmd(e, ok);
        vec++; if (!ok || e.op !== 3'd1 || e.c != 5 || e.row !== 16'd1) begin
            miss++; $display("FAIL rr_mr1 got op=%0d cyc=%0d row=%0d want 1/5/1", e.op, e.c, e.row);
        end
    endtask

    initial begin
        vec       = 0;
        miss      = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_bank  = 2'd0;
        req_row   = 16'd0;
        req_col   = 10'd0;
        test_reset();
        test_init();
        test_refresh_idle();
        test_read_closed();
        test_write_hit();
        test_row_conflict();
        test_refresh_open();
        test_refresh_mid_act();
        test_rst_mid_rw();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
